// File: rtl/register_read_port_pkg.sv
// rtl/register_read_port_pkg.sv - shared widths and constants for the register read port
package register_read_port_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int ZERO_REG   = 0;

  typedef logic [1:0] fifo_count_t;
endpackage

// File: rtl/register_read_port_resp_fifo.sv
// rtl/register_read_port_resp_fifo.sv - 2-entry response queue with push/pop and occupancy count
module read_resp_fifo
  import register_read_port_pkg::*;
#(
  parameter int W = REG_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output fifo_count_t  count_o,
  output logic [W-1:0] data_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  fifo_count_t  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ pop_i;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Empty queue reads as zero so a stale word never leaks onto the output.
  assign data_o  = (count_q == 2'd0) ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/register_read_port.sv
// rtl/register_read_port.sv - handshaked register-file read port with same-cycle write bypass
module register_read_port
  import register_read_port_pkg::*;
#(
  parameter int N      = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] reg_rd_addr,
  input  logic [N-1:0]      reg_rd_data,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]      wr_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N-1:0]      resp_data
);

  fifo_count_t  count;
  logic         accept;
  logic         pop;
  logic [N-1:0] cap_word;

  assign reg_rd_addr = req_addr;
  // Ready depends only on occupancy, keeping resp_ready off the request path.
  assign req_ready   = (count != 2'd2);
  assign resp_valid  = (count != 2'd0);
  assign accept      = req_valid && req_ready;
  assign pop         = resp_valid && resp_ready;

  always_comb begin
    cap_word = reg_rd_data;
    if (req_addr == ADDR_W'(ZERO_REG)) begin
      cap_word = '0;
    end else if (wr_enable && (wr_addr == req_addr)) begin
      cap_word = wr_data;
    end
  end

  read_resp_fifo #(
    .W(N)
  ) u_resp_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (accept),
    .pop_i  (pop),
    .data_i (cap_word),
    .count_o(count),
    .data_o (resp_data)
  );

endmodule

// File: tb/tb_register_read_port.sv
// tb/tb_register_read_port.sv - randomized bench for register_read_port against a queue model
module tb_register_read_port;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  logic [31:0] regs [32];
  logic [31:0] exp_q [$];
  int          tests_run;
  int          tests_failed;

  assign reg_rd_data = regs[reg_rd_addr];

  register_read_port dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data),
    .wr_enable  (wr_enable),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [4:0] addr, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (addr == 5'd0) return 32'h0;
    if (we && wa == addr) return wd;
    return regs[addr];
  endfunction

  // Drive one cycle from just after a falling edge, check, then advance the model.
  task automatic step(input logic rv, input logic [4:0] ra, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic rr);
    logic        exp_ready, exp_valid, acc, pp;
    logic [31:0] word;
    req_valid  = rv;
    req_addr   = ra;
    wr_enable  = we;
    wr_addr    = wa;
    wr_data    = wd;
    resp_ready = rr;
    #1;
    exp_ready = (exp_q.size() != 2);
    exp_valid = (exp_q.size() != 0);
    check_eq("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    check_eq("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
    check_eq("resp_data", resp_data, exp_valid ? exp_q[0] : 32'h0);
    check_eq("reg_rd_addr", {27'b0, reg_rd_addr}, {27'b0, ra});
    acc  = rv && exp_ready;
    pp   = rr && exp_valid;
    word = ref_word(ra, we, wa, wd);
    @(posedge clk);
    @(negedge clk);
    if (pp) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(word);
    if (we && wa != 5'd0) regs[wa] = wd;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0]    = 32'hBAD0_0001;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    wr_enable  = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check_eq("rst_resp_data", resp_data, 32'h0);
    reset = 1'b0;

    regs[7] = 32'hDEADBEEF;
    step(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);

    regs[9] = 32'h0;
    step(1'b1, 5'd9, 1'b1, 5'd9, 32'h12345678, 1'b1);
    step(1'b1, 5'd0, 1'b1, 5'd0, 32'h55AA55AA, 1'b1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    check_eq("reg0_not_written", regs[0], 32'hBAD0_0001);

    regs[1] = 32'h1111_0001;
    regs[2] = 32'h2222_0002;
    regs[3] = 32'h3333_0003;
    step(1'b1, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);

    regs[4] = 32'hA;
    step(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 5'd4, 32'hB, 1'b0);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);

    for (int i = 0; i < 16; i++) step(1'b1, 5'(i + 8), 1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);

    step(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0);
    #2;
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    check_eq("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check_eq("midrst_resp_data", resp_data, 32'h0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] ra, wa;
      ra = 5'($urandom_range(0, 7));
      wa = ($urandom % 2 == 0) ? ra : 5'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, ra, 1'($urandom % 2), wa, $urandom,
           $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
